// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file, one synchronous write port and two
// independent registered read ports, with write-to-read bypass, out-of-range
// detection and a clear sequencer that zeroes every entry on reset or request.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   clear / busy          request a full clear (IDLE only) / clear in progress
//   wr_en/wr_addr/wr_data write port; wr_err flags an out-of-range write
//   rd_en_x/rd_addr_x     read request, port x in {a, b}
//   rd_data_x/rd_valid_x  registered read data and 1-cycle valid pulse
//   rd_err_x              out-of-range read, pulses with rd_valid_x
module regfile_2r1w #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    output logic              rd_err_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b,
    output logic              rd_err_b,
    output logic              wr_err
);

    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ADDR_W1 = ADDR_W + 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable for the range test
    localparam logic [ADDR_W:0]   DEPTH_EXT = ADDR_W1'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr_q;

    logic idle;
    logic wr_ok;
    logic rd_ok_a, rd_ok_b;
    logic rd_in_a, rd_in_b;
    logic byp_a, byp_b;

    // Exact decode: no wrap, upper addresses are errors
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_EXT;
    endfunction

    assign idle    = (state_q == ST_IDLE);
    assign wr_ok   = idle && wr_en && in_range(wr_addr);
    assign rd_ok_a = idle && rd_en_a;
    assign rd_ok_b = idle && rd_en_b;
    assign rd_in_a = in_range(rd_addr_a);
    assign rd_in_b = in_range(rd_addr_b);
    assign byp_a   = wr_ok && (wr_addr == rd_addr_a);
    assign byp_b   = wr_ok && (wr_addr == rd_addr_b);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (ptr_q == LAST_PTR) state_d = ST_IDLE;
            ST_IDLE:  if (clear)             state_d = ST_CLEAR;
            default:                         state_d = ST_CLEAR;
        endcase
    end

    // Clear pointer and busy flag; busy mirrors the next state so it is registered
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            busy  <= 1'b1;
        end else begin
            busy <= (state_d == ST_CLEAR);
            if (state_q == ST_CLEAR) begin
                ptr_q <= ptr_q + ADDR_W'(1);
            end else begin
                ptr_q <= '0;
            end
        end
    end

    // Storage: clear sequencer has priority, writes only land in IDLE
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem[IDX_W'(ptr_q)] <= '0;
            end else if (wr_ok) begin
                mem[IDX_W'(wr_addr)] <= wr_data;
            end
        end
    end

    // Read port A: out-of-range returns 0, same-cycle write is forwarded
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_err_a   <= 1'b0;
        end else begin
            rd_valid_a <= rd_ok_a;
            rd_err_a   <= rd_ok_a && !rd_in_a;
            if (rd_ok_a) begin
                if (!rd_in_a)   rd_data_a <= '0;
                else if (byp_a) rd_data_a <= wr_data;
                else            rd_data_a <= mem[IDX_W'(rd_addr_a)];
            end
        end
    end

    // Read port B: identical to port A
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
            rd_err_b   <= 1'b0;
        end else begin
            rd_valid_b <= rd_ok_b;
            rd_err_b   <= rd_ok_b && !rd_in_b;
            if (rd_ok_b) begin
                if (!rd_in_b)   rd_data_b <= '0;
                else if (byp_b) rd_data_b <= wr_data;
                else            rd_data_b <= mem[IDX_W'(rd_addr_b)];
            end
        end
    end

    // Write error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= idle && wr_en && !in_range(wr_addr);
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed bench for regfile_2r1w. A full-size instance
// (DEPTH=256) covers clear timing, read/write/bypass and clear requests; a
// small instance (DEPTH=20, ADDR_W=5) covers out-of-range handling.
module tb_regfile_2r1w;

    logic clock;
    logic reset;

    // Full-size instance signals
    logic       clear, busy, wr_en, wr_err;
    logic [7:0] wr_addr, wr_data;
    logic       rd_en_a, rd_valid_a, rd_err_a;
    logic [7:0] rd_addr_a, rd_data_a;
    logic       rd_en_b, rd_valid_b, rd_err_b;
    logic [7:0] rd_addr_b, rd_data_b;

    // Small instance signals
    logic       s_clear, s_busy, s_wr_en, s_wr_err;
    logic [4:0] s_wr_addr;
    logic [7:0] s_wr_data;
    logic       s_rd_en_a, s_rd_valid_a, s_rd_err_a;
    logic [4:0] s_rd_addr_a;
    logic [7:0] s_rd_data_a;
    logic       s_rd_en_b, s_rd_valid_b, s_rd_err_b;
    logic [4:0] s_rd_addr_b;
    logic [7:0] s_rd_data_b;

    int n_assert;
    int n_fail;
    int cnt;
    logic seen_valid;

    regfile_2r1w #(.DATA_W(8), .DEPTH(256), .ADDR_W(8)) u_dut (
        .clock(clock), .reset(reset), .clear(clear), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_valid_a(rd_valid_a), .rd_err_a(rd_err_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .rd_valid_b(rd_valid_b), .rd_err_b(rd_err_b),
        .wr_err(wr_err)
    );

    regfile_2r1w #(.DATA_W(8), .DEPTH(20), .ADDR_W(5)) u_small (
        .clock(clock), .reset(reset), .clear(s_clear), .busy(s_busy),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_en_a(s_rd_en_a), .rd_addr_a(s_rd_addr_a), .rd_data_a(s_rd_data_a),
        .rd_valid_a(s_rd_valid_a), .rd_err_a(s_rd_err_a),
        .rd_en_b(s_rd_en_b), .rd_addr_b(s_rd_addr_b), .rd_data_b(s_rd_data_b),
        .rd_valid_b(s_rd_valid_b), .rd_err_b(s_rd_err_b),
        .wr_err(s_wr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle past it before sampling
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic s_wr(input logic [4:0] addr, input logic [7:0] data);
        s_wr_en   = 1'b1;
        s_wr_addr = addr;
        s_wr_data = data;
        step();
        s_wr_en   = 1'b0;
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
    endtask

    initial begin
        logic [7:0] addrs [6];
        logic [7:0] exps  [4];
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
        s_clear = 1'b0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
        s_rd_en_a = 1'b0; s_rd_addr_a = '0; s_rd_en_b = 1'b0; s_rd_addr_b = '0;

        // 1. Reset state and clear duration
        step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_valid_a", 32'(rd_valid_a), 32'd0);
        chk("rst_valid_b", 32'(rd_valid_b), 32'd0);
        chk("rst_data_a", 32'(rd_data_a), 32'd0);
        chk("rst_err_a", 32'(rd_err_a), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        reset = 1'b0;
        wait_busy_low(cnt);
        chk("busy_len_reset", 32'(cnt), 32'd256);
        chk("small_busy_done", 32'(s_busy), 32'd0);
        rd_en_a = 1'b1; rd_addr_a = 8'd7;
        step();
        chk("rd7_data", 32'(rd_data_a), 32'h00);
        chk("rd7_valid", 32'(rd_valid_a), 32'd1);
        chk("rd7_err", 32'(rd_err_a), 32'd0);
        rd_en_a = 1'b0;
        step();
        chk("idle_valid_a", 32'(rd_valid_a), 32'd0);

        // 2. Writes then back-to-back reads on port A
        wr(8'd0, 8'd2);
        wr(8'd2, 8'd3);
        wr(8'd4, 8'd4);
        wr(8'd20, 8'd5);
        addrs[0] = 8'd0; addrs[1] = 8'd2; addrs[2] = 8'd4; addrs[3] = 8'd20;
        exps[0]  = 8'd2; exps[1]  = 8'd3; exps[2]  = 8'd4; exps[3]  = 8'd5;
        for (int i = 0; i < 4; i++) begin
            rd_en_a = 1'b1; rd_addr_a = addrs[i];
            step();
            chk($sformatf("rd_seq_data_%0d", i), 32'(rd_data_a), 32'(exps[i]));
            chk($sformatf("rd_seq_valid_%0d", i), 32'(rd_valid_a), 32'd1);
        end
        rd_en_a = 1'b0;
        step();
        chk("hold_valid_a", 32'(rd_valid_a), 32'd0);
        chk("hold_data_a", 32'(rd_data_a), 32'd5);

        // Both ports on the same address
        rd_en_a = 1'b1; rd_addr_a = 8'd2; rd_en_b = 1'b1; rd_addr_b = 8'd2;
        step();
        chk("same_addr_a", 32'(rd_data_a), 32'd3);
        chk("same_addr_b", 32'(rd_data_b), 32'd3);
        chk("same_addr_vb", 32'(rd_valid_b), 32'd1);
        rd_en_a = 1'b0; rd_en_b = 1'b0;

        // 3. Bypass: write and both reads of entry 9 in one cycle
        wr(8'd9, 8'h11);
        wr_en = 1'b1; wr_addr = 8'd9; wr_data = 8'hAA;
        rd_en_a = 1'b1; rd_addr_a = 8'd9; rd_en_b = 1'b1; rd_addr_b = 8'd9;
        step();
        wr_en = 1'b0; rd_en_b = 1'b0;
        chk("byp_a", 32'(rd_data_a), 32'hAA);
        chk("byp_b", 32'(rd_data_b), 32'hAA);
        step();
        rd_en_a = 1'b0;
        chk("byp_after", 32'(rd_data_a), 32'hAA);

        // 4. Out-of-range handling on DEPTH=20, ADDR_W=5
        s_wr(5'd5, 8'h5A);
        s_wr(5'd19, 8'h3C);
        s_wr(5'd25, 8'hFF);
        chk("s_wr_err_set", 32'(s_wr_err), 32'd1);
        step();
        chk("s_wr_err_clr", 32'(s_wr_err), 32'd0);
        s_rd_en_a = 1'b1; s_rd_addr_a = 5'd5;
        step();
        chk("s_rd5_nowrap", 32'(s_rd_data_a), 32'h5A);
        chk("s_rd5_err", 32'(s_rd_err_a), 32'd0);
        s_rd_addr_a = 5'd25;
        step();
        chk("s_rd25_data", 32'(s_rd_data_a), 32'h00);
        chk("s_rd25_err", 32'(s_rd_err_a), 32'd1);
        chk("s_rd25_valid", 32'(s_rd_valid_a), 32'd1);
        s_rd_addr_a = 5'd19; s_rd_en_b = 1'b1; s_rd_addr_b = 5'd20;
        step();
        chk("s_rd19_data", 32'(s_rd_data_a), 32'h3C);
        chk("s_rd19_err", 32'(s_rd_err_a), 32'd0);
        chk("s_rd20_err_b", 32'(s_rd_err_b), 32'd1);
        chk("s_rd20_data_b", 32'(s_rd_data_b), 32'h00);
        s_rd_addr_a = 5'd31; s_rd_en_b = 1'b0;
        step();
        chk("s_rd31_err", 32'(s_rd_err_a), 32'd1);
        s_rd_en_a = 1'b0;
        step();
        chk("s_err_drop", 32'(s_rd_err_a), 32'd0);
        chk("s_valid_drop", 32'(s_rd_valid_a), 32'd0);

        // 5. Clear request after filling entries
        wr(8'd0, 8'h10);
        wr(8'd1, 8'h11);
        wr(8'd2, 8'h12);
        wr(8'd3, 8'h13);
        wr(8'd200, 8'h99);
        clear = 1'b1; rd_en_a = 1'b1; rd_addr_a = 8'd1;
        step();
        clear = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_cycle_read", 32'(rd_data_a), 32'h11);
        chk("clr_cycle_valid", 32'(rd_valid_a), 32'd1);
        wr_en = 1'b1; wr_addr = 8'd50; wr_data = 8'h77; rd_addr_a = 8'd3;
        seen_valid = 1'b0;
        cnt = 0;
        while (busy && cnt < 1000) begin
            step();
            cnt++;
            seen_valid = seen_valid | rd_valid_a;
        end
        wr_en = 1'b0; rd_en_a = 1'b0;
        chk("busy_len_clear", 32'(cnt), 32'd256);
        chk("no_valid_busy", 32'(seen_valid), 32'd0);
        chk("data_held_busy", 32'(rd_data_a), 32'h11);
        addrs[0] = 8'd0; addrs[1] = 8'd1; addrs[2] = 8'd2;
        addrs[3] = 8'd3; addrs[4] = 8'd50; addrs[5] = 8'd200;
        for (int i = 0; i < 6; i++) begin
            rd_en_a = 1'b1; rd_addr_a = addrs[i];
            rd_en_b = 1'b1; rd_addr_b = addrs[i];
            step();
            chk($sformatf("cleared_a_%0d", addrs[i]), 32'(rd_data_a), 32'h00);
            chk($sformatf("cleared_b_%0d", addrs[i]), 32'(rd_data_b), 32'h00);
        end
        rd_en_a = 1'b0; rd_en_b = 1'b0;

        // 6. Reset mid-clear restarts the full sequence
        wr(8'd0, 8'h43);
        wr(8'd200, 8'h42);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (100) step();
        chk("mid_clear_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd1);
        wait_busy_low(cnt);
        chk("busy_len_restart", 32'(cnt), 32'd256);
        rd_en_a = 1'b1; rd_addr_a = 8'd200; rd_en_b = 1'b1; rd_addr_b = 8'd0;
        step();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        chk("restart_rd200", 32'(rd_data_a), 32'h00);
        chk("restart_rd0", 32'(rd_data_b), 32'h00);
        wr(8'd7, 8'h55);
        rd_en_a = 1'b1; rd_addr_a = 8'd7;
        step();
        rd_en_a = 1'b0;
        chk("post_restart_rw", 32'(rd_data_a), 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
